// File: rtl/mem_1rw_arb2.sv
// mem_1rw_arb2: round-robin arbiter that shares one single-port (1RW)
// synchronous memory between two requesters, m0 and m1.
//   - Grants are combinational in the request cycle. At most one access
//     reaches the memory per cycle.
//   - When both requesters ask in the same cycle, the one not served last wins.
//   - Read data returns one cycle after the grant, qualified by a
//     per-requester valid strobe.
// Optional feature: define MEM_1RW_ARB2_STARVE_CHK_EN to add simulation-only
// starvation counters and a grant-exclusivity check.
module mem_1rw_arb2 #(
    parameter int ADDR_WIDTH = 8,
    parameter int WORD_BYTES = 8,
    parameter int MAX_WAIT   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    m0_req,
    input  logic                    m0_we,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [8*WORD_BYTES-1:0] m0_wr_data,
    input  logic [WORD_BYTES-1:0]   m0_be,
    output logic                    m0_gnt,
    output logic                    m0_rd_valid,
    output logic [8*WORD_BYTES-1:0] m0_rd_data,
    input  logic                    m1_req,
    input  logic                    m1_we,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [8*WORD_BYTES-1:0] m1_wr_data,
    input  logic [WORD_BYTES-1:0]   m1_be,
    output logic                    m1_gnt,
    output logic                    m1_rd_valid,
    output logic [8*WORD_BYTES-1:0] m1_rd_data,
    output logic                    mem_ce,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [8*WORD_BYTES-1:0] mem_wr_data,
    output logic [WORD_BYTES-1:0]   mem_be,
    input  logic [8*WORD_BYTES-1:0] mem_rd_data
);

    // A zero starvation limit would make the optional checker fire immediately.
    if (MAX_WAIT < 1) begin : g_bad_max_wait
        $error("mem_1rw_arb2: MAX_WAIT must be at least 1");
    end

    logic [1:0] req;
    logic [1:0] gnt;
    logic       gnt_id;
    logic [1:0] rd_valid;

    // Requester id (0 or 1) of the most recent grant. Reset to 1 so that m0 wins first.
    logic       last_gnt_reg;
    logic       last_gnt_next;
    // A granted read is in flight: the memory returns its data in the next cycle.
    logic       pend_rd_reg;
    logic       pend_rd_next;
    logic       pend_id_reg;
    logic       pend_id_next;

    assign req = {m1_req, m0_req};

    // Arbitration: single requesters win outright; on a tie the requester
    // that was not served last wins. Nothing is granted while in reset.
    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            if (req == 2'b11) begin
                gnt = last_gnt_reg ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    assign gnt_id = gnt[1];
    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];

    // Memory port is driven by whichever requester holds the grant.
    assign mem_ce      = |gnt;
    assign mem_we      = mem_ce & (gnt_id ? m1_we : m0_we);
    assign mem_addr    = gnt_id ? m1_addr    : m0_addr;
    assign mem_wr_data = gnt_id ? m1_wr_data : m0_wr_data;
    assign mem_be      = gnt_id ? m1_be      : m0_be;

    // Next-state: remember the winner, and flag reads whose data returns next cycle.
    always_comb begin
        last_gnt_next = last_gnt_reg;
        pend_rd_next  = 1'b0;
        pend_id_next  = pend_id_reg;
        if (mem_ce) begin
            last_gnt_next = gnt_id;
        end
        if (mem_ce && !mem_we) begin
            pend_rd_next = 1'b1;
            pend_id_next = gnt_id;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_reg <= 1'b1;
            pend_rd_reg  <= 1'b0;
            pend_id_reg  <= 1'b0;
        end else begin
            last_gnt_reg <= last_gnt_next;
            pend_rd_reg  <= pend_rd_next;
            pend_id_reg  <= pend_id_next;
        end
    end

    // Read-return steering. The strobe comes straight from flops. It is also
    // masked by rst, so that a read granted just before reset never reports
    // completion.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_valid
        assign rd_valid[gi] = pend_rd_reg & (pend_id_reg == 1'(gi)) & ~rst;
    end

    assign m0_rd_valid = rd_valid[0];
    assign m1_rd_valid = rd_valid[1];
    assign m0_rd_data  = mem_rd_data;
    assign m1_rd_data  = mem_rd_data;

`ifdef MEM_1RW_ARB2_STARVE_CHK_EN
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [1:0] gnt_obs;

    // The checker watches the output ports, so forcing a port is visible to it.
    assign gnt_obs = {m1_gnt, m0_gnt};

    for (genvar gi = 0; gi < 2; gi++) begin : g_starve
        logic [CW-1:0] wait_cnt_reg;

        // Count consecutive cycles of an unanswered request.
        always_ff @(posedge clk) begin
            if (rst || !req[gi] || gnt_obs[gi]) begin
                wait_cnt_reg <= '0;
            end else if (wait_cnt_reg != CW'(MAX_WAIT)) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end
        end

        // Report a requester that has waited the full starvation limit.
        always_ff @(posedge clk) begin
            if (!rst && wait_cnt_reg == CW'(MAX_WAIT)) begin
                $display("%M %0t EROARE: starvation m%0d", $time, gi);
                $stop;
            end
        end
    end

    // The two grants must never be asserted together.
    always_ff @(posedge clk) begin
        if (!rst && m0_gnt && m1_gnt) begin
            $display("%M %0t EROARE: m0_gnt and m1_gnt both asserted", $time);
            $stop;
        end
    end
`else
    // Checker disabled: no counters and no checks.
`endif

endmodule

// File: tb/tb_mem_1rw_arb2.sv
// Testbench for mem_1rw_arb2.
//   - Two requester drivers present randomized and directed traffic.
//   - A behavioural 1RW memory (with byte enables) answers the DUT's memory port.
//   - A negedge monitor uses a reference model to predict the grant winner,
//     the memory-port contents and the read-return data.
//   - Expected read data is queued per requester when a read is granted.
//     It is popped when that requester's rd_valid appears.
module tb_mem_1rw_arb2;
    localparam int AW = 8;
    localparam int WB = 8;
    localparam int DW = 8 * WB;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [1:0]    req = '0;
    logic [1:0]    we  = '0;
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];
    logic [WB-1:0] be    [2];

    logic          m0_gnt, m1_gnt, m0_rd_valid, m1_rd_valid;
    logic [DW-1:0] m0_rd_data, m1_rd_data;
    logic          mem_ce, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic [WB-1:0] mem_be;
    logic [DW-1:0] mem_rd_data = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_1rw_arb2 #(.ADDR_WIDTH(AW), .WORD_BYTES(WB), .MAX_WAIT(16)) dut (
        .clk(clk), .rst(rst),
        .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wr_data(wdata[0]), .m0_be(be[0]),
        .m0_gnt(m0_gnt), .m0_rd_valid(m0_rd_valid), .m0_rd_data(m0_rd_data),
        .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wr_data(wdata[1]), .m1_be(be[1]),
        .m1_gnt(m1_gnt), .m1_rd_valid(m1_rd_valid), .m1_rd_data(m1_rd_data),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_be(mem_be), .mem_rd_data(mem_rd_data)
    );

    // Behavioural single-port memory with a registered read port.
    logic [DW-1:0] phys_mem [256];
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) begin
                for (int b = 0; b < WB; b++)
                    if (mem_be[b]) phys_mem[mem_addr][8*b +: 8] <= mem_wr_data[8*b +: 8];
            end else begin
                mem_rd_data <= phys_mem[mem_addr];
            end
        end
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [256];
    int            ref_last = 1;
    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];
    logic [1:0]    exp_rv = '0;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [WB-1:0] b);
        logic [DW-1:0] r;
        r = old_w;
        for (int k = 0; k < WB; k++)
            if (b[k]) r[8*k +: 8] = new_w[8*k +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT outputs with the reference model mid-cycle.
    int            mon_win;
    logic [DW-1:0] mon_exp;
    always @(negedge clk) begin
        if (rst) begin
            chk("gnt_in_rst", DW'({m1_gnt, m0_gnt}), '0);
            chk("ce_in_rst", DW'(mem_ce), '0);
            chk("we_in_rst", DW'(mem_we), '0);
            chk("rv_in_rst", DW'({m1_rd_valid, m0_rd_valid}), '0);
            ref_last = 1;
            exp_rv   = '0;
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            // Read returns due this cycle.
            chk("m0_rd_valid", DW'(m0_rd_valid), DW'(exp_rv[0]));
            chk("m1_rd_valid", DW'(m1_rd_valid), DW'(exp_rv[1]));
            if (exp_rv[0] && m0_rd_valid && exp_q0.size() > 0) begin
                mon_exp = exp_q0.pop_front();
                chk("m0_rd_data", m0_rd_data, mon_exp);
                $display("ret m0 data=%h", m0_rd_data);
            end
            if (exp_rv[1] && m1_rd_valid && exp_q1.size() > 0) begin
                mon_exp = exp_q1.pop_front();
                chk("m1_rd_data", m1_rd_data, mon_exp);
                $display("ret m1 data=%h", m1_rd_data);
            end
            // Winner: a lone requester, or the one not served last on a tie.
            if (req == 2'b11)   mon_win = 1 - ref_last;
            else if (req[0])    mon_win = 0;
            else if (req[1])    mon_win = 1;
            else                mon_win = -1;
            chk("gnt", DW'({m1_gnt, m0_gnt}), (mon_win < 0) ? '0 : DW'(1 << mon_win));
            chk("mem_ce", DW'(mem_ce), DW'(mon_win >= 0));
            exp_rv = '0;
            if (mon_win >= 0) begin
                chk("mem_we", DW'(mem_we), DW'(we[mon_win]));
                chk("mem_addr", DW'(mem_addr), DW'(addr[mon_win]));
                chk("mem_be", DW'(mem_be), DW'(be[mon_win]));
                ref_last = mon_win;
                if (we[mon_win]) begin
                    chk("mem_wr_data", mem_wr_data, wdata[mon_win]);
                    ref_mem[addr[mon_win]] = merge(ref_mem[addr[mon_win]], wdata[mon_win], be[mon_win]);
                    $display("txn m%0d WR addr=%h data=%h be=%h", mon_win, addr[mon_win],
                             wdata[mon_win], be[mon_win]);
                end else begin
                    if (mon_win == 0) exp_q0.push_back(ref_mem[addr[0]]);
                    else              exp_q1.push_back(ref_mem[addr[1]]);
                    exp_rv[mon_win] = 1'b1;
                    $display("txn m%0d RD addr=%h", mon_win, addr[mon_win]);
                end
            end
        end
    end

    // Stimulus helpers: present a transaction, and advance one cycle while
    // dropping requests that were granted.
    task automatic issue(input int i, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [WB-1:0] b);
        req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d; be[i] = b;
    endtask

    task automatic step();
        logic [1:0] g;
        @(negedge clk);
        g = {m1_gnt, m0_gnt};
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++)
            if (g[i]) req[i] = 1'b0;
    endtask

    initial begin
        int n_rd;
        for (int i = 0; i < 2; i++) begin
            addr[i] = '0; wdata[i] = '0; be[i] = '0;
        end
        for (int a = 0; a < 256; a++) begin
            phys_mem[a] = {8{a[7:0]}} ^ 64'hA5C3_0F96_5A3C_F069;
            ref_mem[a]  = {8{a[7:0]}} ^ 64'hA5C3_0F96_5A3C_F069;
        end
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // Both requesters issue reads back to back: strict alternation, m0 first.
        n_rd = 0;
        repeat (6) begin
            for (int i = 0; i < 2; i++)
                if (!req[i]) begin
                    issue(i, 1'b0, AW'(8'h20 + n_rd), '0, '1);
                    n_rd++;
                end
            step();
        end
        repeat (3) step();

        // m0 write then read back the same word.
        issue(0, 1'b1, 8'h10, 64'h1122334455667788, 8'hFF);
        step();
        issue(0, 1'b0, 8'h10, '0, 8'hFF);
        step();
        step();

        // m1 single-byte write, then m0 reads the same address the next cycle.
        issue(1, 1'b1, 8'h10, 64'h00000000000000FF, 8'h01);
        step();
        issue(0, 1'b0, 8'h10, '0, 8'hFF);
        step();
        step();

        // Lone requester holding req is granted every cycle.
        for (int k = 0; k < 5; k++) begin
            issue(1, 1'b1, AW'(8'h40 + k), {$urandom, $urandom}, WB'($urandom));
            step();
        end

        // Read granted, then reset in the next cycle with both requesting.
        issue(0, 1'b0, 8'h30, '0, 8'hFF);
        step();
        rst = 1'b1;
        issue(0, 1'b0, 8'h31, '0, 8'hFF);
        issue(1, 1'b0, 8'h32, '0, 8'hFF);
        step();
        rst = 1'b0;
        repeat (3) step();

        // Randomized traffic over a small address window to force collisions.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++)
                if (!req[i] && $urandom_range(0, 99) < 60)
                    issue(i, 1'($urandom), AW'($urandom_range(0, 15)),
                          {$urandom, $urandom}, WB'($urandom));
            step();
        end
        repeat (5) step();
        chk("drain_outstanding", DW'(exp_q0.size() + exp_q1.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_1rw_arb2.md
Name: mem_1rw_arb2

Overview:
- Round-robin arbiter that shares one single-port (1RW) synchronous memory between two requesters, m0 and m1.
- Each requester issues read or write transactions with a req/gnt handshake.
- Read data comes back with a per-requester valid strobe one cycle after the grant.
- Sits between two masters (e.g. CPU-side and DMA-side) and the memory instance.

Parameters:
ADDR_WIDTH  8  address width, identical to the memory's
WORD_BYTES  8  data width = 8*WORD_BYTES bits; byte-enable width = WORD_BYTES
MAX_WAIT    16  starvation limit in cycles, used only with the optional feature

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
m0_req  input  1  requester 0 transaction request
m0_we  input  1  requester 0: 1 = write, 0 = read
m0_addr  input  ADDR_WIDTH  requester 0 address
m0_wr_data  input  8*WORD_BYTES  requester 0 write data
m0_be  input  WORD_BYTES  requester 0 byte enables
m0_gnt  output  1  requester 0 transaction accepted this cycle
m0_rd_valid  output  1  requester 0 read data valid
m0_rd_data  output  8*WORD_BYTES  requester 0 read data
m1_*  (same set as m0_*)  requester 1
mem_ce  output  1  memory chip enable
mem_we  output  1  memory write enable
mem_addr  output  ADDR_WIDTH  memory address
mem_wr_data  output  8*WORD_BYTES  memory write data
mem_be  output  WORD_BYTES  memory byte enables
mem_rd_data  input  8*WORD_BYTES  memory read data; registered, valid 1 cycle after ce & ~we

Behaviour:
- Reset and clocking:
  - One clock; reset is synchronous and active-high.
  - Sampled at posedge clk: rst=1 forces last_gnt=1 (requester 0 wins first), m0_rd_valid=0, m1_rd_valid=0, pend_rd=0, pend_id=0.
  - While rst=1, combinational outputs are forced low: m0_gnt, m1_gnt, mem_ce, mem_we. mem_* data and address are don't-care.
- Handshake:
  - A requester asserts mX_req with stable we/addr/wr_data/be.
  - The transfer occurs in the cycle where mX_req & mX_gnt = 1.
  - The requester holds its fields until that cycle.
  - A requester may deassert req only after its gnt.
- Arbitration (combinational, same cycle as req):
  - Only m0_req: m0_gnt=1.
  - Only m1_req: m1_gnt=1.
  - Both requesting: grant the requester != last_gnt.
  - Neither requesting: no grant, mem_ce=0.
  - m0_gnt and m1_gnt are never 1 together.
  - last_gnt updates to the granted id at posedge only when a grant occurs; otherwise it holds.
- Memory drive:
  - mem_ce = m0_gnt | m1_gnt.
  - mem_we, mem_addr, mem_wr_data, mem_be are muxed from the granted requester.
  - Exactly one memory access per cycle, so full throughput is 1 transaction/cycle.
- Read return:
  - On a granted read (gnt & ~we): register pend_rd=1, pend_id=granted id; otherwise pend_rd=0.
  - Next cycle: mX_rd_valid = pend_rd & (pend_id==X). mX_rd_valid is registered (reset 0).
  - mX_rd_data = mem_rd_data for both requesters; it is meaningful only while the matching rd_valid is 1.
  - Latency from granted read to rd_valid is 1 cycle.
  - Back-to-back reads from alternating requesters return in grant order with no bubbles.
- Writes produce no response; gnt is the completion.
- Boundary conditions:
  - Write and read to the same address in consecutive cycles from different requesters: the read returns the newly written data, by memory ordering.
  - Same requester holding req continuously while the other is idle: granted every cycle.
  - rst asserted in the cycle after a granted read: rd_valid stays 0 and the pending read is discarded.

Optional Feature:
- Macro: MEM_1RW_ARB2_STARVE_CHK_EN.
- Defined:
  - Per-requester wait counter, width sufficient for MAX_WAIT.
  - Counter increments each cycle mX_req & ~mX_gnt, and clears on grant, on ~req, or on rst.
  - When it reaches MAX_WAIT: $display "%M %0t EROARE: starvation m<X>" with the time, then $stop.
  - Also checks that m0_gnt & m1_gnt is never 1; any violation triggers $display + $stop.
- Undefined: no counters and no checks; the logic is otherwise identical.

Test Plan:
- Reset then only m0 writes addr 0x10 data 0x11..88, be=0xFF -> m0_gnt=1 same cycle; mem_ce=1, mem_we=1, mem_addr=0x10; no rd_valid.
- m0 reads 0x10 -> m0_gnt=1; next cycle m0_rd_valid=1, m0_rd_data=0x1122334455667788; m1_rd_valid=0.
- Both req continuously for 6 cycles, starting right after reset -> grants go m0,m1,m0,m1,m0,m1; with reads at distinct addresses, rd_valid alternates with 1-cycle latency.
- m1 writes be=0x01 data 0xFF to 0x10, next cycle m0 reads 0x10 -> m0 rd_data = 0x11223344556677FF.
- m0 read granted, rst=1 next cycle -> m0_rd_valid=0, mem_ce=0; after rst release with both req -> m0 granted first.
- With MEM_1RW_ARB2_STARVE_CHK_EN and MAX_WAIT=4: tie m1_gnt low via force, hold m1_req -> error message and $stop after 4 cycles; without the macro -> no message.
